// File: rtl/alu_exec_ctrl_if.sv
// Instruction handshake, ALU drive/return and status bus of the execute-stage sequencer.
// master = instruction source and ALU side; slave = the sequencer itself.
interface alu_exec_ctrl_if;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] instr_op;
  logic [7:0] instr_operand;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic       alu_sub;
  logic [2:0] alu_op_select;
  logic [7:0] alu_result;
  logic [7:0] acc;
  logic       zero_flag;
  logic       neg_flag;
  logic       div_zero_flag;
  logic       done;

  modport master (
    output instr_valid, instr_op, instr_operand, alu_result,
    input  instr_ready, alu_a, alu_b, alu_sub, alu_op_select,
    input  acc, zero_flag, neg_flag, div_zero_flag, done
  );

  modport slave (
    input  instr_valid, instr_op, instr_operand, alu_result,
    output instr_ready, alu_a, alu_b, alu_sub, alu_op_select,
    output acc, zero_flag, neg_flag, div_zero_flag, done
  );
endinterface

// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer: owns accumulator and data register, holds ALU inputs stable for a
// per-op settle time, then captures the combinational ALU result and updates status flags.
module alu_exec_ctrl #(
  parameter int unsigned SETTLE_CYCLES        = 1,
  parameter int unsigned MULDIV_SETTLE_CYCLES = 4,
  parameter logic [7:0]  ACC_RESET            = 8'h00
) (
  input logic             clk,
  input logic             rst_n,
  alu_exec_ctrl_if.slave  bus
);

  localparam logic [2:0] OpSub = 3'd1;
  localparam logic [2:0] OpMul = 3'd4;
  localparam logic [2:0] OpDiv = 3'd5;
  localparam logic [2:0] OpLda = 3'd6;
  localparam logic [2:0] OpNop = 3'd7;

  typedef enum logic {StIdle, StExec} state_e;

  state_e     state_q, state_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] data_q, data_d;
  logic [2:0] op_q, op_d;
  logic [7:0] cnt_q, cnt_d;
  logic       zero_q, zero_d;
  logic       neg_q, neg_d;
  logic       dz_q, dz_d;
  logic       done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= ACC_RESET;
      data_q  <= 8'h00;
      op_q    <= 3'd0;
      cnt_q   <= 8'h00;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    data_d  = data_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    dz_d    = dz_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.instr_valid) begin
          op_d   = bus.instr_op;
          data_d = bus.instr_operand;
          done_d = 1'b1;
          if (bus.instr_op == OpLda) begin
            acc_d  = bus.instr_operand;
            zero_d = (bus.instr_operand == 8'h00);
            neg_d  = bus.instr_operand[7];
            dz_d   = 1'b0;
          end else if (bus.instr_op == OpNop) begin
            // Completes immediately with no state change.
          end else if (bus.instr_op == OpDiv && bus.instr_operand == 8'h00) begin
            // Divide by zero never reaches the ALU capture.
            dz_d = 1'b1;
          end else begin
            done_d  = 1'b0;
            state_d = StExec;
            cnt_d   = (bus.instr_op == OpMul || bus.instr_op == OpDiv) ?
                      8'(MULDIV_SETTLE_CYCLES) : 8'(SETTLE_CYCLES);
          end
        end
      end
      StExec: begin
        if (cnt_q == 8'd1) begin
          acc_d   = bus.alu_result;
          zero_d  = (bus.alu_result == 8'h00);
          neg_d   = bus.alu_result[7];
          dz_d    = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end
        cnt_d = cnt_q - 8'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  // ALU inputs come straight from registers so they stay constant across EXEC.
  assign bus.instr_ready   = (state_q == StIdle);
  assign bus.alu_a         = acc_q;
  assign bus.alu_b         = data_q;
  assign bus.alu_op_select = op_q;
  assign bus.alu_sub       = (op_q == OpSub);
  assign bus.acc           = acc_q;
  assign bus.zero_flag     = zero_q;
  assign bus.neg_flag      = neg_q;
  assign bus.div_zero_flag = dz_q;
  assign bus.done          = done_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Self-checking bench for alu_exec_ctrl: behavioural ALU, result scoreboard, scenario tasks.
module tb_alu_exec_ctrl;
  localparam int unsigned SETTLE  = 1;
  localparam int unsigned MULDIV  = 4;
  localparam logic [7:0]  ACC_RST = 8'h00;

  typedef struct packed {
    logic [7:0] acc;
    logic       z;
    logic       n;
    logic       dz;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_exec_ctrl_if bus();

  alu_exec_ctrl #(
    .SETTLE_CYCLES       (SETTLE),
    .MULDIV_SETTLE_CYCLES(MULDIV),
    .ACC_RESET           (ACC_RST)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Behavioural 8-bit ALU.
  logic [15:0] prod;
  assign prod = 16'(bus.alu_a) * 16'(bus.alu_b);
  always_comb begin
    bus.alu_result = 8'h00;
    case (bus.alu_op_select)
      3'd0: bus.alu_result = bus.alu_a + bus.alu_b;
      3'd1: bus.alu_result = bus.alu_a - bus.alu_b;
      3'd2: bus.alu_result = bus.alu_a & bus.alu_b;
      3'd3: bus.alu_result = bus.alu_a | bus.alu_b;
      3'd4: bus.alu_result = prod[7:0];
      3'd5: bus.alu_result = (bus.alu_b == 8'h00) ? 8'hFF : bus.alu_a / bus.alu_b;
      default: bus.alu_result = 8'h00;
    endcase
  end

  int n_checks = 0;
  int n_pass = 0;
  res_t exp_q[$];
  logic [7:0] m_acc;
  logic m_z, m_n, m_dz;

  function automatic void model_push(input logic [2:0] op, input logic [7:0] b);
    logic [7:0] r;
    logic [15:0] p;
    r = m_acc;
    if (op == 3'd7) begin
      r = m_acc;
    end else if (op == 3'd5 && b == 8'h00) begin
      m_dz = 1'b1;
    end else begin
      case (op)
        3'd0: r = m_acc + b;
        3'd1: r = m_acc - b;
        3'd2: r = m_acc & b;
        3'd3: r = m_acc | b;
        3'd4: begin p = 16'(m_acc) * 16'(b); r = p[7:0]; end
        3'd5: r = m_acc / b;
        default: r = b;
      endcase
      m_acc = r;
      m_z   = (r == 8'h00);
      m_n   = r[7];
      m_dz  = 1'b0;
    end
    exp_q.push_back({m_acc, m_z, m_n, m_dz});
  endfunction

  function automatic void model_reset();
    m_acc = ACC_RST;
    m_z   = 1'b0;
    m_n   = 1'b0;
    m_dz  = 1'b0;
    exp_q.delete();
  endfunction

  function automatic res_t observe();
    return {bus.acc, bus.zero_flag, bus.neg_flag, bus.div_zero_flag};
  endfunction

  // Issues one instruction, waits for done; returns scoreboard entry, observation and latency.
  task automatic run_instr(input logic [2:0] op, input logic [7:0] b, output res_t e,
                           output res_t o, output int lat, output logic sub_and,
                           output logic sub_or);
    int guard;
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr_op = op;
    bus.instr_operand = b;
    guard = 0;
    while (!bus.instr_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    model_push(op, b);
    #1;
    bus.instr_valid = 1'b0;
    bus.instr_op = 3'($urandom);
    bus.instr_operand = 8'($urandom);
    lat = 0;
    sub_and = 1'b1;
    sub_or = 1'b0;
    while (!bus.done && lat < 50) begin
      sub_and &= bus.alu_sub;
      sub_or |= bus.alu_sub;
      @(posedge clk);
      #1;
      lat++;
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    o = observe();
  endtask

  task automatic test_reset();
    bus.instr_valid = 1'b0;
    bus.instr_op = 3'd0;
    bus.instr_operand = 8'h00;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (observe() !== {ACC_RST, 3'b000})
      $display("FAIL reset_state got %h want %h", observe(), {ACC_RST, 3'b000});
    else n_pass++;
    n_checks++;
    if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done);
    else n_pass++;
    n_checks++;
    if (bus.instr_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", bus.instr_ready);
    else n_pass++;
    n_checks++;
    if ({bus.alu_a, bus.alu_b} !== 16'h0000)
      $display("FAIL reset_alu_ab got %h want 0000", {bus.alu_a, bus.alu_b});
    else n_pass++;
    n_checks++;
    if (bus.alu_sub !== 1'b0) $display("FAIL reset_alu_sub got %b want 0", bus.alu_sub);
    else n_pass++;
  endtask

  task automatic test_sub_flags();
    res_t e, o;
    int lat;
    logic sa, so;
    run_instr(3'd6, 8'h03, e, o, lat, sa, so);
    n_checks++;
    if (o !== e || lat != 0) $display("FAIL lda_03 got %h/%0d want %h/0", o, lat, e);
    else n_pass++;
    run_instr(3'd1, 8'h05, e, o, lat, sa, so);
    n_checks++;
    if (o !== e) $display("FAIL sub_05 got %h want %h", o, e);
    else n_pass++;
    n_checks++;
    if (o !== {8'hFE, 3'b010}) $display("FAIL sub_05_const got %h want %h", o, {8'hFE, 3'b010});
    else n_pass++;
    n_checks++;
    if (lat != int'(SETTLE)) $display("FAIL sub_latency got %0d want %0d", lat, SETTLE);
    else n_pass++;
    n_checks++;
    if (sa !== 1'b1) $display("FAIL sub_alu_sub got %b want 1", sa);
    else n_pass++;
  endtask

  task automatic test_muldiv_chain();
    res_t e, o;
    int lat;
    logic sa, so;
    run_instr(3'd6, 8'h0C, e, o, lat, sa, so);
    run_instr(3'd4, 8'h03, e, o, lat, sa, so);
    n_checks++;
    if (o !== e || o.acc !== 8'h24) $display("FAIL mul_03 got %h want %h", o, e);
    else n_pass++;
    n_checks++;
    if (lat != int'(MULDIV)) $display("FAIL mul_latency got %0d want %0d", lat, MULDIV);
    else n_pass++;
    n_checks++;
    if (so !== 1'b0) $display("FAIL mul_alu_sub got %b want 0", so);
    else n_pass++;
    run_instr(3'd5, 8'h05, e, o, lat, sa, so);
    n_checks++;
    if (o !== e || o.acc !== 8'h07 || lat != int'(MULDIV))
      $display("FAIL div_05 got %h/%0d want %h/%0d", o, lat, e, MULDIV);
    else n_pass++;
    run_instr(3'd2, 8'h07, e, o, lat, sa, so);
    n_checks++;
    if (o !== e || o.acc !== 8'h07) $display("FAIL and_07 got %h want %h", o, e);
    else n_pass++;
    run_instr(3'd1, 8'h07, e, o, lat, sa, so);
    n_checks++;
    if (o !== e || o !== {8'h00, 3'b100}) $display("FAIL sub_to_zero got %h want %h", o, e);
    else n_pass++;
    run_instr(3'd3, 8'h81, e, o, lat, sa, so);
    n_checks++;
    if (o !== e || o.acc !== 8'h81) $display("FAIL or_81 got %h want %h", o, e);
    else n_pass++;
    run_instr(3'd7, 8'h55, e, o, lat, sa, so);
    n_checks++;
    if (o !== e || lat != 0) $display("FAIL nop got %h/%0d want %h/0", o, lat, e);
    else n_pass++;
  endtask

  task automatic test_div_zero();
    res_t e, o;
    int lat;
    logic sa, so;
    run_instr(3'd6, 8'h40, e, o, lat, sa, so);
    run_instr(3'd5, 8'h00, e, o, lat, sa, so);
    n_checks++;
    if (o !== e || o !== {8'h40, 3'b001} || lat != 0)
      $display("FAIL div_zero got %h/%0d want %h/0", o, lat, e);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.done !== 1'b0) $display("FAIL div_zero_single_pulse got %b want 0", bus.done);
    else n_pass++;
    run_instr(3'd0, 8'h01, e, o, lat, sa, so);
    n_checks++;
    if (o !== e || o !== {8'h41, 3'b000} || lat != int'(SETTLE))
      $display("FAIL add_after_dz got %h/%0d want %h/%0d", o, lat, e, SETTLE);
    else n_pass++;
  endtask

  task automatic test_reset_mid_exec();
    int guard;
    logic seen_done;
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr_op = 3'd4;
    bus.instr_operand = 8'h03;
    guard = 0;
    while (!bus.instr_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (bus.acc !== ACC_RST || bus.instr_ready !== 1'b1 || bus.done !== 1'b0)
      $display("FAIL mid_reset got acc=%h rdy=%b done=%b want acc=%h rdy=1 done=0",
               bus.acc, bus.instr_ready, bus.done, ACC_RST);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      seen_done |= bus.done;
    end
    n_checks++;
    if (seen_done !== 1'b0 || bus.instr_ready !== 1'b1 || observe() !== {ACC_RST, 3'b000})
      $display("FAIL post_reset got done=%b rdy=%b st=%h want done=0 rdy=1 st=%h",
               seen_done, bus.instr_ready, observe(), {ACC_RST, 3'b000});
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    res_t e, o;
    int lat, accepts, dones, cyc;
    logic sa, so, will_acc, overlap_ok, extra_done;
    run_instr(3'd6, 8'hFE, e, o, lat, sa, so);
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr_op = 3'd0;
    bus.instr_operand = 8'h01;
    accepts = 0;
    dones = 0;
    cyc = 0;
    overlap_ok = 1'b1;
    while ((accepts < 5 || dones < 5) && cyc < 200) begin
      will_acc = bus.instr_valid && bus.instr_ready;
      if (will_acc && accepts > 0 && !bus.done) overlap_ok = 1'b0;
      @(posedge clk);
      if (will_acc) begin
        model_push(3'd0, 8'h01);
        accepts++;
      end
      #1;
      if (accepts == 5) bus.instr_valid = 1'b0;
      if (bus.done) begin
        dones++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        o = observe();
        n_checks++;
        if (o !== e) $display("FAIL b2b_add_%0d got %h want %h", dones, o, e);
        else n_pass++;
      end
      @(negedge clk);
      cyc++;
    end
    extra_done = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      extra_done |= bus.done;
    end
    n_checks++;
    if (dones != 5 || extra_done !== 1'b0)
      $display("FAIL b2b_done_count got %0d extra=%b want 5 extra=0", dones, extra_done);
    else n_pass++;
    n_checks++;
    if (overlap_ok !== 1'b1) $display("FAIL b2b_overlap got %b want 1", overlap_ok);
    else n_pass++;
    n_checks++;
    if (bus.acc !== 8'h03) $display("FAIL b2b_final_acc got %h want 03", bus.acc);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sub_flags();
    test_muldiv_chain();
    test_div_zero();
    test_reset_mid_exec();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
